// File: rtl/result_arb_mux_if.sv
// Channel bundle for result_arb_mux: N producer channels in, one registered result out.
interface result_arb_mux_if #(
    parameter int W  = 64,
    parameter int N  = 8,
    parameter int SW = $clog2(N)
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/result_arb_mux.sv
// N-to-1 result multiplexer with direct or round-robin selection feeding a single
// registered output slot that reloads in the same edge it is drained.
module result_arb_mux #(
    parameter int W  = 64,
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input logic            clk,
    input logic            rst_b,
    result_arb_mux_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] chan_q, chan_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          loadEn;
    logic          grantValid;
    logic [SW-1:0] grantIdx;
    logic [N-1:0]  readyVec;
    int            idx;

    assign loadEn = (state_q == EMPTY) || bus.out_ready;

    // Direct mode ignores out-of-range sel; round-robin scans upward from ptr with wrap.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        idx        = 0;
        if (!bus.mode) begin
            if (int'(bus.sel) < N) begin
                if (bus.in_valid[bus.sel]) begin
                    grantValid = 1'b1;
                    grantIdx   = bus.sel;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (!grantValid && bus.in_valid[idx]) begin
                    grantValid = 1'b1;
                    grantIdx   = SW'(idx);
                end
            end
        end
    end

    always_comb begin
        readyVec = '0;
        if (rst_b && loadEn && grantValid) readyVec[grantIdx] = 1'b1;
    end

    assign bus.in_ready = readyVec;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (loadEn) begin
            if (grantValid) begin
                state_d = FULL;
                data_d  = bus.in_data[int'(grantIdx)*W +: W];
                chan_d  = grantIdx;
                if (bus.mode) ptr_d = (int'(grantIdx) == N-1) ? '0 : grantIdx + SW'(1);
            end else begin
                // Drained with nothing to replace it: data and channel keep their last values.
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
endmodule

// File: tb/tb_result_arb_mux.sv
// Directed bench for result_arb_mux: an 8x64 instance for the main scenarios and a
// 5x8 instance to exercise a direct-mode sel beyond the channel count.
module tb_result_arb_mux;
    logic clk;
    logic rst_b;
    int   passCount;
    int   checkCount;

    result_arb_mux_if #(.W(64), .N(8)) bus ();
    result_arb_mux_if #(.W(8),  .N(5)) bus2 ();

    result_arb_mux #(.W(64), .N(8)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));
    result_arb_mux #(.W(8),  .N(5)) dut2 (.clk(clk), .rst_b(rst_b), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] expWord(input int i);
        if (i == 5) return 64'hDEAD_BEEF;
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    task automatic test_reset();
        rst_b = 1'b0;
        bus.mode = 1'b1; bus.sel = '0; bus.in_valid = 8'hFF; bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) bus.in_data[i*64 +: 64] = expWord(i);
        bus2.mode = 1'b0; bus2.sel = '0; bus2.in_valid = '0; bus2.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) bus2.in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        #3;
        checkCount++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b, expected 0", bus.out_valid); else passCount++;
        checkCount++; if (bus.out_data !== 64'h0) $display("[TB] FAIL reset_data: got %h, expected 0", bus.out_data); else passCount++;
        checkCount++; if (bus.out_chan !== 3'd0) $display("[TB] FAIL reset_chan: got %0d, expected 0", bus.out_chan); else passCount++;
        checkCount++; if (bus.in_ready !== 8'h00) $display("[TB] FAIL reset_in_ready: got %h, expected 00", bus.in_ready); else passCount++;
        @(posedge clk); @(posedge clk);
        bus.in_valid = 8'h00;
        @(negedge clk); rst_b = 1'b1;
        @(posedge clk); #1;
        checkCount++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL release_no_transfer: got %b, expected 0", bus.out_valid); else passCount++;
    endtask

    task automatic test_direct();
        bus.mode = 1'b0; bus.sel = 3'd5; bus.in_valid = 8'hFF; bus.out_ready = 1'b1;
        #1;
        checkCount++; if (bus.in_ready !== 8'h20) $display("[TB] FAIL direct_in_ready: got %h, expected 20", bus.in_ready); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (bus.out_data !== 64'hDEAD_BEEF) $display("[TB] FAIL direct_data: got %h, expected deadbeef", bus.out_data); else passCount++;
        checkCount++; if (bus.out_chan !== 3'd5) $display("[TB] FAIL direct_chan: got %0d, expected 5", bus.out_chan); else passCount++;
        checkCount++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL direct_valid: got %b, expected 1", bus.out_valid); else passCount++;
    endtask

    task automatic test_round_robin();
        bus.mode = 1'b1; bus.in_valid = 8'hFF; bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            checkCount++; if (bus.out_chan !== 3'(i % 8)) $display("[TB] FAIL rr_chan[%0d]: got %0d, expected %0d", i, bus.out_chan, i % 8); else passCount++;
            checkCount++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL rr_valid[%0d]: got %b, expected 1", i, bus.out_valid); else passCount++;
        end
        bus.in_valid = 8'h00;
    endtask

    task automatic test_backpressure();
        // ptr is 1 here after the nine round-robin grants.
        bus.mode = 1'b0; bus.sel = 3'd2; bus.in_valid = 8'hFF; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkCount++; if (bus.out_chan !== 3'd2) $display("[TB] FAIL bp_load_chan: got %0d, expected 2", bus.out_chan); else passCount++;
        bus.out_ready = 1'b0; bus.mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkCount++; if (bus.in_ready !== 8'h00) $display("[TB] FAIL bp_in_ready[%0d]: got %h, expected 00", i, bus.in_ready); else passCount++;
            @(posedge clk); #1;
            checkCount++; if (bus.out_chan !== 3'd2) $display("[TB] FAIL bp_chan[%0d]: got %0d, expected 2", i, bus.out_chan); else passCount++;
            checkCount++; if (bus.out_data !== expWord(2)) $display("[TB] FAIL bp_data[%0d]: got %h, expected %h", i, bus.out_data, expWord(2)); else passCount++;
            checkCount++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL bp_valid[%0d]: got %b, expected 1", i, bus.out_valid); else passCount++;
        end
        bus.out_ready = 1'b1;
        #1;
        checkCount++; if (bus.in_ready !== 8'h02) $display("[TB] FAIL bp_release_ready: got %h, expected 02", bus.in_ready); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (bus.out_chan !== 3'd1) $display("[TB] FAIL bp_reload_chan: got %0d, expected 1", bus.out_chan); else passCount++;
        checkCount++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL bp_reload_valid: got %b, expected 1", bus.out_valid); else passCount++;
        bus.in_valid = 8'h00;
        @(posedge clk); #1;
        checkCount++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL idle_valid: got %b, expected 0", bus.out_valid); else passCount++;
        checkCount++; if (bus.out_chan !== 3'd1) $display("[TB] FAIL idle_chan_hold: got %0d, expected 1", bus.out_chan); else passCount++;
        checkCount++; if (bus.out_data !== expWord(1)) $display("[TB] FAIL idle_data_hold: got %h, expected %h", bus.out_data, expWord(1)); else passCount++;
    endtask

    task automatic test_sparse_wrap();
        // ptr is 2; a lone valid on channel 5 moves it to 6.
        bus.mode = 1'b1; bus.in_valid = 8'h20; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkCount++; if (bus.out_chan !== 3'd5) $display("[TB] FAIL sparse_setup_chan: got %0d, expected 5", bus.out_chan); else passCount++;
        bus.in_valid = 8'h09;
        #1;
        checkCount++; if (bus.in_ready !== 8'h01) $display("[TB] FAIL wrap_ready: got %h, expected 01", bus.in_ready); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (bus.out_chan !== 3'd0) $display("[TB] FAIL wrap_chan: got %0d, expected 0", bus.out_chan); else passCount++;
        checkCount++; if (bus.in_ready !== 8'h08) $display("[TB] FAIL sparse_ready: got %h, expected 08", bus.in_ready); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (bus.out_chan !== 3'd3) $display("[TB] FAIL sparse_chan: got %0d, expected 3", bus.out_chan); else passCount++;
        bus.mode = 1'b0; bus.sel = 3'd4;
        #1;
        checkCount++; if (bus.in_ready !== 8'h00) $display("[TB] FAIL nogrant_ready: got %h, expected 00", bus.in_ready); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL nogrant_valid: got %b, expected 0", bus.out_valid); else passCount++;
        checkCount++; if (bus.out_chan !== 3'd3) $display("[TB] FAIL nogrant_chan_hold: got %0d, expected 3", bus.out_chan); else passCount++;
    endtask

    task automatic test_sel_out_of_range();
        bus2.mode = 1'b0; bus2.sel = 3'd7; bus2.in_valid = 5'h1F; bus2.out_ready = 1'b1;
        #1;
        checkCount++; if (bus2.in_ready !== 5'h00) $display("[TB] FAIL oor_ready: got %h, expected 00", bus2.in_ready); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (bus2.out_valid !== 1'b0) $display("[TB] FAIL oor_valid: got %b, expected 0", bus2.out_valid); else passCount++;
        bus2.sel = 3'd4;
        #1;
        checkCount++; if (bus2.in_ready !== 5'h10) $display("[TB] FAIL top_sel_ready: got %h, expected 10", bus2.in_ready); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (bus2.out_data !== 8'hA4) $display("[TB] FAIL top_sel_data: got %h, expected a4", bus2.out_data); else passCount++;
        bus2.sel = 3'd5;
        @(posedge clk); #1;
        checkCount++; if (bus2.out_valid !== 1'b0) $display("[TB] FAIL oor_drop_valid: got %b, expected 0", bus2.out_valid); else passCount++;
        checkCount++; if (bus2.out_chan !== 3'd4) $display("[TB] FAIL oor_chan_hold: got %0d, expected 4", bus2.out_chan); else passCount++;
    endtask

    task automatic test_reset_mid();
        // ptr is 4 from the sparse test; direct loads leave it there.
        bus.mode = 1'b0; bus.sel = 3'd6; bus.in_valid = 8'hFF; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkCount++; if (bus.out_chan !== 3'd6 || bus.out_valid !== 1'b1) $display("[TB] FAIL midrst_setup: got chan %0d valid %b, expected 6/1", bus.out_chan, bus.out_valid); else passCount++;
        bus.out_ready = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        checkCount++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL midrst_valid: got %b, expected 0", bus.out_valid); else passCount++;
        checkCount++; if (bus.out_data !== 64'h0) $display("[TB] FAIL midrst_data: got %h, expected 0", bus.out_data); else passCount++;
        checkCount++; if (bus.out_chan !== 3'd0) $display("[TB] FAIL midrst_chan: got %0d, expected 0", bus.out_chan); else passCount++;
        checkCount++; if (bus.in_ready !== 8'h00) $display("[TB] FAIL midrst_ready: got %h, expected 00", bus.in_ready); else passCount++;
        bus.mode = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkCount++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL midrst_held_valid: got %b, expected 0", bus.out_valid); else passCount++;
        @(negedge clk); rst_b = 1'b1;
        #1;
        checkCount++; if (bus.in_ready !== 8'h01) $display("[TB] FAIL postrst_ready: got %h, expected 01", bus.in_ready); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (bus.out_chan !== 3'd0) $display("[TB] FAIL postrst_chan: got %0d, expected 0", bus.out_chan); else passCount++;
        checkCount++; if (bus.out_data !== expWord(0)) $display("[TB] FAIL postrst_data: got %h, expected %h", bus.out_data, expWord(0)); else passCount++;
        checkCount++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL postrst_valid: got %b, expected 1", bus.out_valid); else passCount++;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        test_reset();
        test_direct();
        test_round_robin();
        test_backpressure();
        test_sparse_wrap();
        test_sel_out_of_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
